// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX arbiter and the planned RX block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } uart_state_e;

    localparam int UART_DATA_W     = 8;
    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between NUM_REQ byte producers, the arbiter and the uart_tx serializer pins.
// Latency: n/a (wires only).
// Backpressure: req_ready is the only accept; producers hold req_valid/req_data until accepted.
// Modports: master = producer/serializer side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_pkg::*;

    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*UART_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           baud_tick;
    logic                           tx_start;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           busy;
    logic [GID_W-1:0]               grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, baud_tick, tx_start, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, baud_tick, tx_start, tx_data, busy, grant_id
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud enable: one-cycle baud_tick every CLK_DIV system clocks.
// Latency: first tick CLK_DIV cycles after reset release.
// Backpressure: none, free-running.
// Ports: clk, rst (sync, active-high), baud_tick (out).
module uart_baud_gen #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        baud_tick = (cnt_q == CNT_LAST);
        cnt_d     = baud_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers (RR or fixed priority).
// Latency: accept -> tx_start 1 cycle; next accept after LOAD + FRAME_TICKS baud ticks + 1.
// Backpressure: req_ready only in IDLE, one-hot; all producers stall while a frame is in flight.
// Ports: clk, rst (sync, active-high), bus (uart_tx_arbiter_if.slave).
// Build option: define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority (no RR pointer).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CLK_DIV     = 434,
    parameter int FRAME_TICKS = 12
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int TCNT_W = $clog2(FRAME_TICKS + 1);

    // The reserved window must at least cover load, one full frame and busy clear.
    if (FRAME_TICKS < UART_FRAME_BITS + 2) begin : g_frame_check
        $error("FRAME_TICKS shorter than one UART frame");
    end

    logic baud_tick;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick)
    );

    logic [NUM_REQ-1:0][UART_DATA_W-1:0] req_bytes;
    assign req_bytes = bus.req_data;

    uart_state_e            state_q,    state_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q,  tx_data_d;
    logic [GID_W-1:0]       grant_id_q, grant_id_d;
    logic [TCNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [NUM_REQ-1:0]     req_ready;
    logic [GID_W-1:0]       win;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest valid index wins; scanning downward leaves the lowest one in win.
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[GID_W'(i)]) begin
                win = GID_W'(i);
            end
        end
    end
`else
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               sum;
    logic [GID_W-1:0] idx;

    // First valid index at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = GID_W'(sum);
            if (!found && bus.req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        tick_cnt_d = tick_cnt_q;
        req_ready  = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // No accept while reset is held, so no byte is lost to the reset.
                if (|bus.req_valid && !rst) begin
                    req_ready[win] = 1'b1;
                    tx_data_d      = req_bytes[win];
                    grant_id_d     = win;
                    tx_start_d     = 1'b1;
                    state_d        = LOAD;
`ifndef UART_ARB_FIXED_PRIO_EN
                    rr_ptr_d       = (win == GID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                end
            end
            LOAD: begin
                // The serializer takes the start on the first tick seen here.
                if (baud_tick) begin
                    tick_cnt_d = '0;
                    tx_start_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TCNT_W'(FRAME_TICKS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            tick_cnt_q <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            tick_cnt_q <= tick_cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.baud_tick = baud_tick;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: randomized byte batches, transaction-level arbitration model.
// Latency: n/a.
// Backpressure: producers hold valid/data until accepted.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int CD = 4;
    localparam int FT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .CLK_DIV     (CD),
        .FRAME_TICKS (FT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ser_exp[$];
    logic [7:0] drv_q[NR][$];
    logic [NR-1:0] acc_mask    = '0;
    logic [NR-1:0] glitch_mask = '0;
    logic [7:0]    glitch_data = 8'h00;
    int   mptr = 0;
    int   mcyc = 0;
    logic mrst = 1'b1;

    // Cycles since reset release: the baud tick is due whenever mcyc mod CD == CD-1.
    always @(posedge clk) begin
        mrst <= rst;
        mcyc <= rst ? 0 : mcyc + 1;
    end

    // Producers: present the head of each queue, drop it once accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_mask[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[i*8 +: 8]  = drv_q[i][0];
                end else begin
                    bus.req_valid[i]        = glitch_mask[i];
                    bus.req_data[i*8 +: 8]  = glitch_data;
                end
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    exp_t       e, pend;
    logic       pend_vld = 1'b0;
    logic       prev_start = 1'b0, prev_tick = 1'b0;
    int         load_len = 0, busy_len = 0;
    logic       ser_act = 1'b0;
    int         ser_n = 0;
    logic [7:0] ser_byte, sb;
    logic [9:0] ser_bits, fr;
    logic [NR-1:0] acc;

    initial begin
        forever begin
            @(negedge clk);
            chk("baud_tick", bus.baud_tick, (mcyc % CD) == CD - 1);
            acc      = bus.req_ready & bus.req_valid;
            acc_mask = acc;
            if (mrst) begin
                chk("rst_tx_start", bus.tx_start, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_grant_id", bus.grant_id, 0);
                chk("rst_tx_data", bus.tx_data, 0);
                pend_vld = 1'b0; load_len = 0; busy_len = 0; ser_act = 1'b0;
                prev_start = 1'b0; prev_tick = bus.baud_tick;
            end else begin
                if (pend_vld) begin
                    chk("acc_tx_start", bus.tx_start, 1);
                    chk("acc_tx_data", bus.tx_data, pend.d);
                    chk("acc_grant_id", bus.grant_id, pend.id);
                    chk("acc_busy", bus.busy, 1);
                    pend_vld = 1'b0;
                end else begin
                    chk("tx_start", bus.tx_start, prev_start && !prev_tick);
                end
                if (bus.busy) chk("ready_while_busy", bus.req_ready, 0);
                if (acc != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_accept", acc, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_ready", bus.req_ready, 1 << e.id);
                        pend = e; pend_vld = 1'b1;
                        ser_exp.push_back(e.d);
                    end
                end
                if (bus.tx_start) load_len++;
                if (bus.busy) busy_len++;
                else if (busy_len > 0) begin
                    chk("busy_len", busy_len, load_len + FT * CD);
                    chk("load_len_range", (load_len >= 1) && (load_len <= CD), 1);
                    busy_len = 0; load_len = 0;
                end
                if (bus.tx_start && !prev_start) chk("frame_overlap", ser_act, 0);
                // Serializer: loads on a tick with tx_start, then one bit per tick, LSB first.
                if (!ser_act && bus.tx_start && bus.baud_tick) begin
                    ser_act = 1'b1; ser_n = 0; ser_byte = bus.tx_data;
                end else if (ser_act && bus.baud_tick) begin
                    fr = {1'b1, ser_byte, 1'b0};
                    ser_bits[ser_n] = fr[ser_n];
                    ser_n++;
                    if (ser_n == UART_FRAME_BITS) begin
                        ser_act = 1'b0;
                        if (ser_exp.size() == 0) chk("ser_unexpected", ser_bits, 0);
                        else begin
                            sb = ser_exp.pop_front();
                            chk("ser_frame", ser_bits, {1'b1, sb, 1'b0});
                        end
                    end
                end
                prev_start = bus.tx_start;
                prev_tick  = bus.baud_tick;
            end
        end
    end

    // Reference model: all queued producers are valid together, so the grant
    // order is just the arbitration rule applied to the non-empty queues.
    task automatic push_batch(input int cnt[NR]);
        logic [7:0] lq[NR][$];
        exp_t x;
        int   w;
        bit   any;
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < cnt[i]; j++) drv_q[i].push_back(8'($urandom));
            lq[i] = drv_q[i];
        end
        forever begin
            any = 0;
            for (int i = 0; i < NR; i++) if (lq[i].size() > 0) any = 1;
            if (!any) break;
            w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NR; i++) if (w < 0 && lq[i].size() > 0) w = i;
`else
            for (int k = 0; k < NR; k++)
                if (w < 0 && lq[(mptr + k) % NR].size() > 0) w = (mptr + k) % NR;
            mptr = (w + 1) % NR;
`endif
            x.id = w;
            x.d  = lq[w].pop_front();
            exp_q.push_back(x);
        end
    endtask

    task automatic drain();
        int  n = 0;
        bit  pending;
        do begin
            pending = (exp_q.size() != 0) || bus.busy;
            for (int i = 0; i < NR; i++) if (drv_q[i].size() != 0) pending = 1;
            if (pending) begin
                @(posedge clk); #2;
                n++;
            end
        end while (pending && n < 5000);
        chk("drain_timeout", n < 5000, 1);
    endtask

    task automatic wait_in_wait();
        int n = 0;
        while (!(bus.busy && !bus.tx_start) && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_wait", n < 500, 1);
    endtask

    int c[NR];
    int ticks, bad;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Idle: ticks every CD cycles, everything else quiet.
        ticks = 0; bad = 0;
        repeat (100) begin
            @(posedge clk); #2;
            ticks += int'(bus.baud_tick);
            if (bus.busy || bus.tx_start || (|bus.req_ready)) bad++;
        end
        chk("idle_ticks", ticks, 25);
        chk("idle_quiet", bad, 0);

        // All four valid together from a fresh pointer.
        push_batch('{2, 1, 1, 1});
        drain();

        // Single request, req 2 with 0xA5.
        drv_q[2].push_back(8'hA5);
        begin
            exp_t x;
            x.id = 2; x.d = 8'hA5;
            exp_q.push_back(x);
`ifndef UART_ARB_FIXED_PRIO_EN
            mptr = 3;
`endif
        end
        drain();

        // Randomized batches.
        repeat (6) begin
            for (int i = 0; i < NR; i++) c[i] = $urandom_range(0, 3);
            push_batch(c);
            drain();
        end

        // Valid pulse on req 1 only while a frame is in WAIT: never accepted.
        push_batch('{1, 0, 0, 0});
        wait_in_wait();
        glitch_mask = 4'b0010; glitch_data = 8'h3C;
        repeat (5) begin
            @(posedge clk); #2;
            chk("glitch_ready1", bus.req_ready[1], 0);
        end
        glitch_mask = '0;
        drain();

        // Reset in WAIT mid-frame, then fresh arbitration from pointer 0.
        push_batch('{0, 2, 0, 2});
        wait_in_wait();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) drv_q[i].delete();
        exp_q.delete();
        ser_exp.delete();
        mptr = 0;
        @(posedge clk); #2;
        chk("mid_rst_tx_start", bus.tx_start, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_grant_id", bus.grant_id, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        push_batch('{1, 0, 1, 0});
        drain();

        chk("exp_empty", exp_q.size(), 0);
        chk("ser_empty", ser_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
